// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned DEF_AWIDTH = 32;
  localparam int unsigned DEF_DWIDTH = 32;
  localparam int unsigned DEF_DEPTH  = 2;

  localparam logic [31:0] RESET_PC   = 32'h0100_0000;
  localparam int unsigned INSN_BYTES = 4;

  // Counters must hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and decode handshake.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
);

  logic              imem_req_valid_o;
  logic              imem_req_ready_i;
  logic [AWIDTH-1:0] imem_addr_o;
  logic              imem_rsp_valid_i;
  logic [DWIDTH-1:0] imem_rdata_i;
  logic              redirect_i;
  logic [AWIDTH-1:0] redirect_pc_i;
  logic              valid_o;
  logic              ready_i;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] insn_o;

  modport master (
    output imem_req_valid_o, imem_addr_o, valid_o, pc_o, insn_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rdata_i,
           redirect_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_addr_o, valid_o, pc_o, insn_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rdata_i,
           redirect_i, redirect_pc_i, ready_i
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small in-order circular queue holding {pc, insn} pairs; flush beats push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = DEF_AWIDTH + DEF_DWIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: storage is deliberately not reset; the pointers and count define which slots are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word requests,
// queues in-order responses for decode and drops stale responses after a redirect.
module fetch
  import fetch_pkg::*;
#(
  parameter int              AWIDTH    = DEF_AWIDTH,
  parameter int              DWIDTH    = DEF_DWIDTH,
  parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(RESET_PC),
  parameter int              DEPTH     = DEF_DEPTH
) (
  input logic    clk,
  input logic    rst,
  fetch_if.master bus
);

  localparam int          CW   = cnt_width(DEPTH);
  localparam int          EW   = AWIDTH + DWIDTH;
  localparam [AWIDTH-1:0] STEP = AWIDTH'(INSN_BYTES);

  logic [AWIDTH-1:0] fetch_pc, rsp_pc, target;
  logic [CW-1:0]     out_cnt, drop_cnt, count, rsp_in;
  logic [CW:0]       in_use;
  logic [EW-1:0]     head, last_q, shown;
  logic              credit_ok, issue, rsp_keep, rsp_drop, pop;
  logic              unused_low_bits;

  assign target          = {bus.redirect_pc_i[AWIDTH-1:2], 2'b00};
  assign unused_low_bits = ^bus.redirect_pc_i[1:0];

  // Outstanding requests plus queued entries may never exceed the queue size,
  // so every response is guaranteed a free slot.
  assign in_use    = {1'b0, out_cnt} + {1'b0, count};
  assign credit_ok = in_use < (CW+1)'(DEPTH);

  assign bus.imem_req_valid_o = !rst && !bus.redirect_i && credit_ok;
  assign bus.imem_addr_o      = fetch_pc;
  assign issue                = bus.imem_req_valid_o && bus.imem_req_ready_i;

  assign rsp_in   = CW'(bus.imem_rsp_valid_i);
  assign rsp_keep = bus.imem_rsp_valid_i && (drop_cnt == '0) && !bus.redirect_i;
  assign rsp_drop = bus.imem_rsp_valid_i && (drop_cnt != '0) && !bus.redirect_i;
  assign pop      = (count != '0) && bus.ready_i && !bus.redirect_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= BASE_ADDR;
      rsp_pc   <= BASE_ADDR;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (bus.redirect_i) begin
      // Everything still in flight (minus a response landing now) becomes stale.
      fetch_pc <= target;
      rsp_pc   <= target;
      out_cnt  <= out_cnt - rsp_in;
      drop_cnt <= out_cnt - rsp_in;
    end else begin
      if (issue)    fetch_pc <= fetch_pc + STEP;
      if (rsp_keep) rsp_pc   <= rsp_pc + STEP;
      out_cnt <= out_cnt + CW'(issue) - rsp_in;
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (pop),
    .flush (bus.redirect_i),
    .din   ({rsp_pc, bus.imem_rdata_i}),
    .count (count),
    .head  (head)
  );

  // Remembers the last presented entry so pc_o/insn_o hold steady while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                last_q <= {BASE_ADDR, DWIDTH'(0)};
    else if (count != '0)   last_q <= head;
  end

  assign shown      = (count != '0) ? head : last_q;
  assign bus.valid_o = (count != '0);
  assign bus.pc_o    = shown[EW-1:DWIDTH];
  assign bus.insn_o  = shown[DWIDTH-1:0];

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> (count != CW'(DEPTH)));

  a_rsp_expected : assert property (@(posedge clk) disable iff (rst)
    bus.imem_rsp_valid_i |-> (out_cnt != '0));

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch stage: memory model with configurable latency, PC reference model,
// expected-entry scoreboard popped by an independent monitor, plus directed scenario checks.
module tb_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_if #(.AWIDTH(32), .DWIDTH(32)) bus ();

  fetch #(
    .AWIDTH    (32),
    .DWIDTH    (32),
    .BASE_ADDR (BASE),
    .DEPTH     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  int          total = 0;
  int          bad   = 0;
  mem_req_t    memq[$];
  logic [31:0] sb[$];
  logic [31:0] acc_log[$];
  logic [31:0] model_pc = BASE;
  int          edge_cnt = 0;
  int          lat      = 1;
  bit          rnd_lat  = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: in order, one response per cycle, never stalls.
  always @(posedge clk) begin
    edge_cnt++;
    #2;
    if (rst || memq.size() == 0 || memq[0].due > edge_cnt + 1) begin
      bus.imem_rsp_valid_i = 1'b0;
      bus.imem_rdata_i     = '0;
    end else begin
      bus.imem_rsp_valid_i = 1'b1;
      bus.imem_rdata_i     = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end
  end

  // Monitor: reference PC model, issue checks and scoreboard pops.
  always @(negedge clk) begin
    logic [31:0] e;
    int          d;
    if (rst) begin
      memq.delete();
      sb.delete();
      model_pc = BASE;
    end else if (bus.redirect_i) begin
      check("no_issue_on_redirect", {31'd0, bus.imem_req_valid_o}, 32'd0);
      sb.delete();
      model_pc = {bus.redirect_pc_i[31:2], 2'b00};
    end else begin
      if (bus.valid_o && bus.ready_i) begin
        if (sb.size() == 0) begin
          check("pop_unexpected", {31'd0, bus.valid_o}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pop_pc", bus.pc_o, e);
          check("pop_insn", bus.insn_o, mem_word(e));
        end
      end
      if (bus.imem_req_valid_o && bus.imem_req_ready_i) begin
        check("issue_addr", bus.imem_addr_o, model_pc);
        acc_log.push_back(bus.imem_addr_o);
        sb.push_back(model_pc);
        d = rnd_lat ? int'($urandom_range(1, 4)) : lat;
        memq.push_back('{bus.imem_addr_o, edge_cnt + 1 + d});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (n < max) begin
      @(negedge clk);
      if (bus.valid_o) break;
      n++;
    end
    check(name, {31'd0, bus.valid_o}, 32'd1);
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (acc_log.size() > i) ? acc_log[i] : 32'hDEAD_DEAD;
  endfunction

  initial begin
    int n;
    rst                  = 1'b1;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rdata_i     = '0;
    bus.redirect_i       = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.ready_i          = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("rst_req_valid", {31'd0, bus.imem_req_valid_o}, 32'd0);
    check("rst_pc", bus.pc_o, BASE);
    check("rst_insn", bus.insn_o, 32'd0);

    // Streaming with latency 1
    @(posedge clk); #1;
    rst = 1'b0; bus.ready_i = 1'b1; bus.imem_req_ready_i = 1'b1;
    acc_log.delete();
    wait_valid("first_valid", 4);
    check("first_pc", bus.pc_o, BASE);
    check("first_insn", bus.insn_o, mem_word(BASE));
    cycles(20);
    check("seq_addr0", log_at(0), 32'h0100_0000);
    check("seq_addr1", log_at(1), 32'h0100_0004);
    check("seq_addr2", log_at(2), 32'h0100_0008);

    // Decode back-pressure: queue fills, requests stop
    bus.ready_i = 1'b0;
    cycles(10);
    @(negedge clk);
    check("sat_valid", {31'd0, bus.valid_o}, 32'd1);
    check("sat_req_valid", {31'd0, bus.imem_req_valid_o}, 32'd0);
    check("sat_head_pc", bus.pc_o, (sb.size() > 0) ? sb[0] : 32'hDEAD_DEAD);
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
    cycles(15);

    // Redirect with requests in flight
    lat = 4;
    cycles(12);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0100_0203;
    acc_log.delete();
    cycles(1);
    bus.redirect_i = 1'b0;
    @(negedge clk);
    check("redir_valid_drop", {31'd0, bus.valid_o}, 32'd0);
    wait_valid("redir_valid", 14);
    check("redir_first_pc", bus.pc_o, 32'h0100_0200);
    check("redir_first_addr", log_at(0), 32'h0100_0200);
    cycles(10);

    // Redirect coinciding with a response and a decode pop
    lat = 1;
    cycles(6);
    n = 0;
    while (n < 20) begin
      @(posedge clk); #3;
      if (bus.imem_rsp_valid_i && bus.valid_o) break;
      n++;
    end
    check("coinc_found", {31'd0, bus.imem_rsp_valid_i && bus.valid_o}, 32'd1);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0100_0400;
    cycles(1);
    bus.redirect_i = 1'b0;
    @(negedge clk);
    check("coinc_no_valid", {31'd0, bus.valid_o}, 32'd0);
    cycles(12);

    // Reset mid-stream
    lat = 3;
    cycles(8);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, bus.valid_o}, 32'd0);
    check("mid_rst_req", {31'd0, bus.imem_req_valid_o}, 32'd0);
    check("mid_rst_pc", bus.pc_o, BASE);
    cycles(2);
    rst = 1'b0;
    acc_log.delete();
    cycles(14);
    check("restart_addr", log_at(0), BASE);

    // PC wrap
    lat = 1;
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFFE;
    acc_log.delete();
    cycles(1);
    bus.redirect_i = 1'b0;
    cycles(12);
    check("wrap_addr0", log_at(0), 32'hFFFF_FFFC);
    check("wrap_addr1", log_at(1), 32'h0000_0000);

    // Randomised latency, back-pressure and redirects against the reference model
    rnd_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bus.ready_i          = ($urandom_range(0, 3) != 0);
      bus.imem_req_ready_i = ($urandom_range(0, 3) != 0);
      bus.redirect_i       = ($urandom_range(0, 29) == 0);
      bus.redirect_pc_i    = $urandom;
      cycles(1);
    end

    // Drain
    bus.redirect_i = 1'b0; bus.imem_req_ready_i = 1'b0; bus.ready_i = 1'b1;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (memq.size() == 0 && sb.size() == 0 && !bus.valid_o) break;
      n++;
    end
    check("drain_sb_empty", sb.size(), 32'd0);
    check("drain_valid", {31'd0, bus.valid_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
